// File: rtl/mem_bus_arbiter.sv
// Three-port arbiter (fetch/execute/loader) in front of a single-port memory.
// Optional MEM_ARB_RR_EN: round-robin between EX and IO; IF always highest.
module mem_bus_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_if,
    input  logic        req_ex,
    input  logic        req_io,
    input  logic [7:0]  addr_if,
    input  logic [7:0]  addr_ex,
    input  logic [7:0]  addr_io,
    input  logic [15:0] wdata_ex,
    input  logic [15:0] wdata_io,
    input  logic        we_ex,
    input  logic        we_io,
    input  logic [1:0]  wait_cycles,
    input  logic [15:0] mem_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [7:0]  mem_addr,
    output logic [15:0] mem_wdata,
    output logic [2:0]  grant,
    output logic        done_if,
    output logic        done_ex,
    output logic        done_io,
    output logic [15:0] rdata,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  grant_q, grant_d;
    logic        mem_en_q, mem_en_d;
    logic        mem_we_q, mem_we_d;
    logic [7:0]  mem_addr_q, mem_addr_d;
    logic [15:0] mem_wdata_q, mem_wdata_d;
    logic [2:0]  done_q, done_d;
    logic [15:0] rdata_q, rdata_d;
    logic        busy_q, busy_d;
    logic [1:0]  cnt_q, cnt_d;

    logic [2:0]  pick;
    logic [7:0]  addr_sel;
    logic [15:0] wdata_sel;
    logic        we_sel;

`ifdef MEM_ARB_RR_EN
    // rr_q = 0 favours EX on an EX/IO tie, 1 favours IO.
    logic rr_q, rr_d;

    always_comb begin
        if (req_if)                pick = 3'b001;
        else if (req_ex && req_io) pick = rr_q ? 3'b100 : 3'b010;
        else if (req_ex)           pick = 3'b010;
        else if (req_io)           pick = 3'b100;
        else                       pick = 3'b000;
    end
`else
    always_comb begin
        if (req_if)      pick = 3'b001;
        else if (req_ex) pick = 3'b010;
        else if (req_io) pick = 3'b100;
        else             pick = 3'b000;
    end
`endif

    // Fetch is read-only, so its write data and strobe are forced to zero.
    always_comb begin
        addr_sel  = pick[0] ? addr_if : (pick[1] ? addr_ex : addr_io);
        wdata_sel = pick[1] ? wdata_ex : (pick[2] ? wdata_io : 16'h0000);
        we_sel    = pick[1] ? we_ex : (pick[2] ? we_io : 1'b0);
    end

    always_comb begin
        // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        grant_d     = grant_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        done_d      = 3'b000;
        rdata_d     = rdata_q;
        busy_d      = busy_q;
        cnt_d       = cnt_q;
`ifdef MEM_ARB_RR_EN
        rr_d        = rr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (|pick) begin
                    state_d     = S_ACCESS;
                    grant_d     = pick;
                    mem_en_d    = 1'b1;
                    mem_we_d    = we_sel;
                    mem_addr_d  = addr_sel;
                    mem_wdata_d = wdata_sel;
                    cnt_d       = wait_cycles;
                    busy_d      = 1'b1;
`ifdef MEM_ARB_RR_EN
                    if (!pick[0]) rr_d = ~rr_q;
`endif
                end
            end
            S_ACCESS: begin
                if (cnt_q == 2'd0) begin
                    state_d  = S_DONE;
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    done_d   = grant_q;
                    if (!mem_we_q) rdata_d = mem_rdata;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                grant_d = 3'b000;
                busy_d  = 1'b0;
            end
            default: begin
                state_d  = S_IDLE;
                grant_d  = 3'b000;
                mem_en_d = 1'b0;
                mem_we_d = 1'b0;
                busy_d   = 1'b0;
                cnt_d    = 2'd0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            grant_q     <= 3'b000;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 8'h00;
            mem_wdata_q <= 16'h0000;
            done_q      <= 3'b000;
            rdata_q     <= 16'h0000;
            busy_q      <= 1'b0;
            cnt_q       <= 2'd0;
`ifdef MEM_ARB_RR_EN
            rr_q        <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            done_q      <= done_d;
            rdata_q     <= rdata_d;
            busy_q      <= busy_d;
            cnt_q       <= cnt_d;
`ifdef MEM_ARB_RR_EN
            rr_q        <= rr_d;
`endif
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign grant     = grant_q;
    assign done_if   = done_q[0];
    assign done_ex   = done_q[1];
    assign done_io   = done_q[2];
    assign rdata     = rdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter; expectations follow MEM_ARB_RR_EN
// when the bench is built with the same macro as the design.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_if = 1'b0, req_ex = 1'b0, req_io = 1'b0;
    logic [7:0]  addr_if = 8'h00, addr_ex = 8'h00, addr_io = 8'h00;
    logic [15:0] wdata_ex = 16'h0000, wdata_io = 16'h0000;
    logic        we_ex = 1'b0, we_io = 1'b0;
    logic [1:0]  wait_cycles = 2'd0;
    logic [15:0] mem_rdata = 16'h0000;
    logic        mem_en, mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [2:0]  grant;
    logic        done_if, done_ex, done_io;
    logic [15:0] rdata;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    mem_bus_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req_if(req_if), .req_ex(req_ex), .req_io(req_io),
        .addr_if(addr_if), .addr_ex(addr_ex), .addr_io(addr_io),
        .wdata_ex(wdata_ex), .wdata_io(wdata_io),
        .we_ex(we_ex), .we_io(we_io),
        .wait_cycles(wait_cycles), .mem_rdata(mem_rdata),
        .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .grant(grant),
        .done_if(done_if), .done_ex(done_ex), .done_io(done_io),
        .rdata(rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // One full transaction starting from IDLE with the winning request already driven.
    task automatic txn(input logic [2:0] g, input logic [7:0] a, input int w,
                       input bit drop, input string tag);
        step();
        check({tag, " grant"},    16'(grant), 16'(g));
        check({tag, " mem_en"},   16'(mem_en), 16'h1);
        check({tag, " mem_addr"}, 16'(mem_addr), 16'(a));
        repeat (w) step();
        step();
        check({tag, " done"},     16'({done_io, done_ex, done_if}), 16'(g));
        check({tag, " en_off"},   16'(mem_en), 16'h0);
        check({tag, " busy_dn"},  16'(busy), 16'h1);
        if (drop) begin
            if (g[0]) req_if = 1'b0;
            if (g[1]) req_ex = 1'b0;
            if (g[2]) req_io = 1'b0;
        end
        step();
        check({tag, " idle_g"},   16'(grant), 16'h0);
        check({tag, " idle_b"},   16'(busy), 16'h0);
        check({tag, " idle_d"},   16'({done_io, done_ex, done_if}), 16'h0);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        check("rst grant",  16'(grant), 16'h0);
        check("rst mem_en", 16'(mem_en), 16'h0);
        check("rst busy",   16'(busy), 16'h0);
        check("rst rdata",  rdata, 16'h0);
        check("rst addr",   16'(mem_addr), 16'h0);
        step();
        step();
        rst_n = 1'b1;

        // Fetch read, zero wait states.
        wait_cycles = 2'd0;
        addr_if     = 8'h10;
        mem_rdata   = 16'h1234;
        req_if      = 1'b1;
        step();
        check("if grant", 16'(grant), 16'h1);
        check("if en",    16'(mem_en), 16'h1);
        check("if we",    16'(mem_we), 16'h0);
        check("if addr",  16'(mem_addr), 16'h10);
        check("if busy",  16'(busy), 16'h1);
        step();
        check("if done",  16'(done_if), 16'h1);
        check("if en0",   16'(mem_en), 16'h0);
        check("if rdata", rdata, 16'h1234);
        check("if gheld", 16'(grant), 16'h1);
        req_if = 1'b0;
        step();
        check("if done0", 16'(done_if), 16'h0);
        check("if gclr",  16'(grant), 16'h0);

        // Execute write, three wait states; inputs change after grant.
        wait_cycles = 2'd3;
        addr_ex     = 8'h20;
        wdata_ex    = 16'hBEEF;
        we_ex       = 1'b1;
        req_ex      = 1'b1;
        step();
        check("ex grant", 16'(grant), 16'h2);
        check("ex en0",   16'(mem_en), 16'h1);
        check("ex we0",   16'(mem_we), 16'h1);
        addr_ex     = 8'h99;
        wdata_ex    = 16'h0000;
        we_ex       = 1'b0;
        wait_cycles = 2'd0;
        mem_rdata   = 16'hDEAD;
        for (int i = 1; i < 4; i++) begin
            step();
            check("ex en",    16'(mem_en), 16'h1);
            check("ex we",    16'(mem_we), 16'h1);
            check("ex addr",  16'(mem_addr), 16'h20);
            check("ex wdata", mem_wdata, 16'hBEEF);
            check("ex early", 16'(done_ex), 16'h0);
        end
        step();
        check("ex done",  16'(done_ex), 16'h1);
        check("ex en_off", 16'(mem_en), 16'h0);
        check("ex rdata", rdata, 16'h1234);
        req_ex = 1'b0;
        step();
        check("ex idle",  16'(busy), 16'h0);

        // All three requests together, each dropped on its own done.
        do_reset();
        wait_cycles = 2'd0;
        addr_if = 8'h01; addr_ex = 8'h02; addr_io = 8'h03;
        we_ex = 1'b0; we_io = 1'b0;
        req_if = 1'b1; req_ex = 1'b1; req_io = 1'b1;
        txn(3'b001, 8'h01, 0, 1'b1, "all if");
        txn(3'b010, 8'h02, 0, 1'b1, "all ex");
        txn(3'b100, 8'h03, 0, 1'b1, "all io");
        step();
        check("all none", 16'(grant), 16'h0);

        // EX held continuously alongside IO.
        do_reset();
        req_ex = 1'b1; req_io = 1'b1;
        txn(3'b010, 8'h02, 0, 1'b0, "hold 1");
`ifdef MEM_ARB_RR_EN
        txn(3'b100, 8'h03, 0, 1'b0, "hold 2");
`else
        txn(3'b010, 8'h02, 0, 1'b0, "hold 2");
`endif
        txn(3'b010, 8'h02, 0, 1'b0, "hold 3");
        req_ex = 1'b0; req_io = 1'b0;

        // Reset in the second ACCESS cycle drops the transaction.
        do_reset();
        wait_cycles = 2'd2;
        addr_io     = 8'h33;
        mem_rdata   = 16'h7777;
        req_io      = 1'b1;
        step();
        check("rsta grant", 16'(grant), 16'h4);
        step();
        check("rsta en",    16'(mem_en), 16'h1);
        rst_n = 1'b0;
        #1;
        check("rsta g0",    16'(grant), 16'h0);
        check("rsta en0",   16'(mem_en), 16'h0);
        check("rsta busy",  16'(busy), 16'h0);
        check("rsta addr",  16'(mem_addr), 16'h0);
        req_io = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rsta nodone", 16'({done_io, done_ex, done_if}), 16'h0);
        end
        rst_n = 1'b1;
        step();
        check("rsta nodone2", 16'({done_io, done_ex, done_if}), 16'h0);
        addr_if = 8'h55;
        req_if  = 1'b1;
        txn(3'b001, 8'h55, 2, 1'b1, "post rst");
        check("post rdata", rdata, 16'h7777);

        // IO request dropped and address changed mid-access.
        wait_cycles = 2'd1;
        addr_io     = 8'h44;
        mem_rdata   = 16'h5A5A;
        req_io      = 1'b1;
        step();
        check("drop grant", 16'(grant), 16'h4);
        req_io  = 1'b0;
        addr_io = 8'h77;
        check("drop addr0", 16'(mem_addr), 16'h44);
        step();
        check("drop addr1", 16'(mem_addr), 16'h44);
        check("drop en1",   16'(mem_en), 16'h1);
        step();
        check("drop done",  16'(done_io), 16'h1);
        check("drop rdata", rdata, 16'h5A5A);
        step();
        check("drop done0", 16'(done_io), 16'h0);
        step();
        check("drop nogr",  16'(grant), 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
